// File: rtl/scoreboard.sv
// Scoreboard comparing a DUT result stream against a golden stream: counts samples,
// mismatches, and tracks best/worst leading-bit accuracy through a 3-stage pipeline.
module scoreboard #(
    parameter int WIDTH = 32
) (
    input  logic             clk_dut,
    input  logic             reset,
    input  logic             enable,
    input  logic             freeze,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_expected,
    input  logic [WIDTH-1:0] i_result,
    output logic [31:0]      o_data_ctr,
    output logic [31:0]      o_error_ctr,
    output logic [31:0]      o_maxacc,
    output logic [31:0]      o_minacc
);

    localparam int ACC_W = $clog2(WIDTH + 1);
    localparam logic [ACC_W-1:0] ACC_FULL = ACC_W'(WIDTH);

    // Handshake: i_valid is a one-way strobe with no ready; a sample is taken at
    // every rising edge where i_valid=1, enable=1 and reset=0, one per cycle.
    logic accept;
    assign accept = i_valid & enable;

    // Stage 1: operand capture
    logic             s1_valid;
    logic [WIDTH-1:0] s1_expected;
    logic [WIDTH-1:0] s1_result;

    always_ff @(posedge clk_dut) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
        end
    end

    always_ff @(posedge clk_dut) begin
        if (accept) begin
            s1_expected <= i_expected;
            s1_result   <= i_result;
        end
    end

    // Accuracy = count of matching bits from the MSB down to the first difference.
    logic [WIDTH-1:0] s1_diff;
    logic [ACC_W-1:0] s1_acc;
    logic             s1_mismatch;

    always_comb begin
        s1_diff     = s1_expected ^ s1_result;
        s1_mismatch = |s1_diff;
        s1_acc      = ACC_FULL;
        for (int i = 0; i < WIDTH; i++) begin
            if (s1_diff[i]) begin
                s1_acc = ACC_W'(WIDTH - 1 - i);
            end
        end
    end

    // Stage 2: accuracy and mismatch flag
    logic             s2_valid;
    logic [ACC_W-1:0] s2_acc;
    logic             s2_mismatch;

    always_ff @(posedge clk_dut) begin
        if (reset) begin
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
        end
    end

    always_ff @(posedge clk_dut) begin
        if (s1_valid) begin
            s2_acc      <= s1_acc;
            s2_mismatch <= s1_mismatch;
        end
    end

    // Stage 3: statistics
    logic [31:0]      data_ctr;
    logic [31:0]      error_ctr;
    logic [ACC_W-1:0] maxacc;
    logic [ACC_W-1:0] minacc;

    logic [31:0]      data_ctr_nxt;
    logic [31:0]      error_ctr_nxt;
    logic [ACC_W-1:0] maxacc_nxt;
    logic [ACC_W-1:0] minacc_nxt;

    // Reset values (max=0, min=WIDTH) make the first sample set both extremes.
    always_comb begin
        data_ctr_nxt  = data_ctr;
        error_ctr_nxt = error_ctr;
        maxacc_nxt    = maxacc;
        minacc_nxt    = minacc;
        if (s2_valid) begin
            if (data_ctr != 32'hFFFF_FFFF) begin
                data_ctr_nxt = data_ctr + 32'd1;
            end
            if (s2_mismatch && (error_ctr != 32'hFFFF_FFFF)) begin
                error_ctr_nxt = error_ctr + 32'd1;
            end
            if (s2_acc > maxacc) begin
                maxacc_nxt = s2_acc;
            end
            if (s2_acc < minacc) begin
                minacc_nxt = s2_acc;
            end
        end
    end

    always_ff @(posedge clk_dut) begin
        if (reset) begin
            data_ctr  <= 32'd0;
            error_ctr <= 32'd0;
            maxacc    <= '0;
            minacc    <= ACC_FULL;
        end else begin
            data_ctr  <= data_ctr_nxt;
            error_ctr <= error_ctr_nxt;
            maxacc    <= maxacc_nxt;
            minacc    <= minacc_nxt;
        end
    end

    // Outputs load the same next values as the counters, so they track in the
    // same cycle when not frozen and resume immediately on release.
    always_ff @(posedge clk_dut) begin
        if (reset) begin
            o_data_ctr  <= 32'd0;
            o_error_ctr <= 32'd0;
            o_maxacc    <= 32'd0;
            o_minacc    <= 32'(ACC_FULL);
        end else if (!freeze) begin
            o_data_ctr  <= data_ctr_nxt;
            o_error_ctr <= error_ctr_nxt;
            o_maxacc    <= 32'(maxacc_nxt);
            o_minacc    <= 32'(minacc_nxt);
        end
    end

endmodule
